// File: rtl/in_dispatch_fsm_if.sv
// ---------------------------------------------------------------------------
// in_dispatch_fsm_if
// Bundles every handshake and data signal between the input dispatcher and
// the FIFOs and merger around it. clk and reset stay plain ports on the
// dispatcher.
//
// Signal summary (direction as seen by the dispatcher, modport master):
//   in_fifo_empty   in   input FIFO empty
//   in_fifo_pop     out  input FIFO read strobe
//   in_data         in   input word (valid the cycle after in_fifo_pop)
//   in_is_varint    in   1 = varint destination, 0 = raw destination
//   in_last         in   word is the last of its record
//   dst_fifo_clr    out  clears both destination FIFOs
//   varint_fifo_*   full in / push, data, index out
//   raw_fifo_*      full in / push, data, index out
//   record_done     in   one-cycle pulse per record completed by the merger
//   dispatch_err    out  sticky error flag
//
// Handshake semantics: every strobe is a one-cycle transfer with no separate
// ready. A pop is only issued when in_fifo_empty was low; the popped word is
// valid on in_* in the following cycle. A push is only issued when the
// destination's full was low in the previous cycle, and *_data_d/*_index_d
// are valid for the whole cycle the push is high. At most one push is high
// at a time.
// ---------------------------------------------------------------------------
interface in_dispatch_fsm_if #(
   parameter int DATA_W = 64
);
   logic              in_fifo_empty;
   logic              in_fifo_pop;
   logic [DATA_W-1:0] in_data;
   logic              in_is_varint;
   logic              in_last;
   logic              dst_fifo_clr;
   logic              varint_fifo_full;
   logic              varint_fifo_push;
   logic [DATA_W-1:0] varint_data_d;
   logic [9:0]        varint_index_d;
   logic              raw_fifo_full;
   logic              raw_fifo_push;
   logic [DATA_W-1:0] raw_data_d;
   logic [9:0]        raw_index_d;
   logic              record_done;
   logic              dispatch_err;

   modport master (
      input  in_fifo_empty, in_data, in_is_varint, in_last,
             varint_fifo_full, raw_fifo_full, record_done,
      output in_fifo_pop, dst_fifo_clr,
             varint_fifo_push, varint_data_d, varint_index_d,
             raw_fifo_push, raw_data_d, raw_index_d, dispatch_err
   );

   modport slave (
      output in_fifo_empty, in_data, in_is_varint, in_last,
             varint_fifo_full, raw_fifo_full, record_done,
      input  in_fifo_pop, dst_fifo_clr,
             varint_fifo_push, varint_data_d, varint_index_d,
             raw_fifo_push, raw_data_d, raw_index_d, dispatch_err
   );
endinterface

// File: rtl/in_dispatch_fsm.sv
// ---------------------------------------------------------------------------
// in_dispatch_fsm
// Pops tagged words from the input FIFO and routes each one to the varint
// FIFO or the raw FIFO, tagging it with a 10-bit record index. The index
// advances after the last word of each record. Optionally limits the number
// of records in flight so the merger's index comparison never aliases.
//
// Ports:
//   clk             clock
//   reset           asynchronous active-low reset
//   bus             in_dispatch_fsm_if.master (FIFO/merger handshakes)
//   o_dbg_state     one-hot FSM state
//   o_dbg_in_index  current record index
//   o_dbg_inflight  records dispatched but not yet completed (0 if disabled)
//
// Build option: define INFLIGHT_LIMIT_EN to compile in the in-flight window,
// the record_done handling and the inflight counter. Without it the window
// is always open and record_done is ignored.
// ---------------------------------------------------------------------------
module in_dispatch_fsm #(
   parameter int DATA_W       = 64,
   parameter int MAX_INFLIGHT = 512
) (
   input  logic                     clk,
   input  logic                     reset,
   in_dispatch_fsm_if.master        bus,
   output logic [4:0]               o_dbg_state,
   output logic [9:0]               o_dbg_in_index,
   output logic [9:0]               o_dbg_inflight
);

   typedef enum logic [4:0] {
      S_INIT     = 5'b00001,
      S_IDLE     = 5'b00010,
      S_POP      = 5'b00100,
      S_LATCH    = 5'b01000,
      S_DISPATCH = 5'b10000
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_hold_data;
   logic              r_hold_varint;
   logic              r_hold_last;
   logic [9:0]        r_in_index;
   logic              r_err;
   // Push strobes are flops that are only ever set while in DISPATCH, so
   // they behave as extra state bits rather than input-dependent outputs.
   logic              r_push_varint;
   logic              r_push_raw;

   logic              w_window_open;
   logic              w_latch_full;
   logic              w_hold_full;

   // LATCH samples full for the destination of the word arriving this cycle,
   // so an unstalled push lands in the first DISPATCH cycle.
   assign w_latch_full = bus.in_is_varint ? bus.varint_fifo_full : bus.raw_fifo_full;
   assign w_hold_full  = r_hold_varint    ? bus.varint_fifo_full : bus.raw_fifo_full;

`ifdef INFLIGHT_LIMIT_EN
   localparam logic [10:0] LP_MAX = 11'(MAX_INFLIGHT);
   logic [9:0] r_inflight;
   logic       w_last_push;

   assign w_last_push    = (r_state == S_DISPATCH) && (r_push_varint || r_push_raw) && r_hold_last;
   assign w_window_open  = ({1'b0, r_inflight} < LP_MAX);
   assign o_dbg_inflight = r_inflight;
`else
   logic       w_unused_done;
   logic [10:0] w_unused_max;

   assign w_unused_done  = bus.record_done;
   assign w_unused_max   = 11'(MAX_INFLIGHT);
   assign w_window_open  = 1'b1;
   assign o_dbg_inflight = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_INIT;
         r_hold_data   <= '0;
         r_hold_varint <= 1'b0;
         r_hold_last   <= 1'b0;
         r_in_index    <= '0;
         r_err         <= 1'b0;
         r_push_varint <= 1'b0;
         r_push_raw    <= 1'b0;
`ifdef INFLIGHT_LIMIT_EN
         r_inflight    <= '0;
`endif
      end else begin
         case (r_state)
            S_INIT: begin
               r_in_index    <= '0;
               r_push_varint <= 1'b0;
               r_push_raw    <= 1'b0;
               r_state       <= S_IDLE;
            end
            S_IDLE: begin
               if (!bus.in_fifo_empty && w_window_open) begin
                  r_state <= S_POP;
               end
            end
            S_POP: begin
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_hold_data   <= bus.in_data;
               r_hold_varint <= bus.in_is_varint;
               r_hold_last   <= bus.in_last;
               r_push_varint <=  bus.in_is_varint && !w_latch_full;
               r_push_raw    <= !bus.in_is_varint && !w_latch_full;
               r_state       <= S_DISPATCH;
            end
            S_DISPATCH: begin
               if (r_push_varint || r_push_raw) begin
                  // Push happens this cycle; the word is gone.
                  r_push_varint <= 1'b0;
                  r_push_raw    <= 1'b0;
                  if (r_hold_last) begin
                     r_in_index <= r_in_index + 10'd1;
                  end
                  r_state <= S_IDLE;
               end else if (!w_hold_full) begin
                  // Full dropped: push next cycle. Only this block pushes, so
                  // the FIFO cannot refill in between.
                  r_push_varint <=  r_hold_varint;
                  r_push_raw    <= !r_hold_varint;
               end
            end
            default: begin
               r_push_varint <= 1'b0;
               r_push_raw    <= 1'b0;
               r_err         <= 1'b1;
               r_state       <= S_INIT;
            end
         endcase

`ifdef INFLIGHT_LIMIT_EN
         // A completion coinciding with a last-word push cancels out.
         if (r_state == S_INIT) begin
            r_inflight <= '0;
         end else if (w_last_push && !bus.record_done) begin
            r_inflight <= r_inflight + 10'd1;
         end else if (!w_last_push && bus.record_done) begin
            if (r_inflight == 10'd0) begin
               r_err <= 1'b1;
            end else begin
               r_inflight <= r_inflight - 10'd1;
            end
         end
`endif
      end
   end

   assign bus.in_fifo_pop      = (r_state == S_POP);
   assign bus.dst_fifo_clr     = (r_state == S_INIT);
   assign bus.varint_fifo_push = r_push_varint;
   assign bus.raw_fifo_push    = r_push_raw;
   assign bus.varint_data_d    = r_hold_data;
   assign bus.raw_data_d       = r_hold_data;
   assign bus.varint_index_d   = r_in_index;
   assign bus.raw_index_d      = r_in_index;
   assign bus.dispatch_err     = r_err;

   assign o_dbg_state    = r_state;
   assign o_dbg_in_index = r_in_index;

endmodule

// File: tb/tb_in_dispatch_fsm.sv
`timescale 1ns/1ps
module tb_in_dispatch_fsm;
   localparam int DATA_W       = 64;
   localparam int MAX_INFLIGHT = 4;
   localparam int W            = DATA_W + 11;

   localparam logic [4:0] ST_INIT     = 5'b00001;
   localparam logic [4:0] ST_IDLE     = 5'b00010;
   localparam logic [4:0] ST_DISPATCH = 5'b10000;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              is_varint;
      logic              last;
      logic              exp_dest;
      logic [9:0]        exp_index;
      logic [9:0]        exp_idx_after;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- DUT ----------------
   logic [4:0] dbg_state;
   logic [9:0] dbg_in_index;
   logic [9:0] dbg_inflight;

   in_dispatch_fsm_if #(.DATA_W(DATA_W)) bus ();

   in_dispatch_fsm #(.DATA_W(DATA_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
      .clk            (clk),
      .reset          (rst_n),
      .bus            (bus),
      .o_dbg_state    (dbg_state),
      .o_dbg_in_index (dbg_in_index),
      .o_dbg_inflight (dbg_inflight)
   );

   // ---------------- scoreboard state ----------------
   int checks        = 0;
   int failures      = 0;
   int push_cnt      = 0;
   int pop_cyc       = 0;
   int push_cyc      = 0;
   int prev_push_cyc = 0;

   logic [W-1:0]        exp_q[$];   // {dest_is_varint, index, data}
   logic [DATA_W+1:0]   src_q[$];   // {is_varint, last, data}

   // Input FIFO model and push monitor, both on the falling edge.
   always @(negedge clk) begin : mon
      logic [DATA_W+1:0] w;
      logic [W-1:0]      got;
      logic [W-1:0]      exp;
      if (bus.in_fifo_pop === 1'b1) begin
         pop_cyc = cyc;
         if (src_q.size() > 0) begin
            w = src_q.pop_front();
            bus.in_is_varint = w[DATA_W+1];
            bus.in_last      = w[DATA_W];
            bus.in_data      = w[DATA_W-1:0];
         end
      end
      bus.in_fifo_empty = (src_q.size() == 0);
      if (bus.varint_fifo_push === 1'b1 || bus.raw_fifo_push === 1'b1) begin
         prev_push_cyc = push_cyc;
         push_cyc      = cyc;
         push_cnt++;
         checks++;
         if (bus.varint_fifo_push === 1'b1 && bus.raw_fifo_push === 1'b1) begin
            failures++;
            $display("FAIL dual_push: both pushes high at cycle %0d, required one", cyc);
         end
         if (bus.varint_fifo_push === 1'b1)
            got = {1'b1, bus.varint_index_d, bus.varint_data_d};
         else
            got = {1'b0, bus.raw_index_d, bus.raw_data_d};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_push: got=%h at cycle %0d, required no push", got, cyc);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               failures++;
               $display("FAIL push_word: got=%h required=%h", got, exp);
            end
         end
      end
   end

   // ---------------- driver / check tasks ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h required=%0h", name, got, exp);
      end
   endtask

   task automatic enq(input logic [DATA_W-1:0] d, input logic v, input logic l);
      src_q.push_back({v, l, d});
   endtask

   task automatic expect_push(input logic v, input logic [9:0] idx, input logic [DATA_W-1:0] d);
      exp_q.push_back({v, idx, d});
   endtask

   task automatic wait_done(input int max_cyc, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_timeout: pending=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_state(input logic [4:0] st, input int max_cyc, input string name);
      int n = 0;
      while (dbg_state !== st && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(dbg_state), 32'(st));
   endtask

   task automatic pulse_done();
      @(negedge clk);
      bus.record_done = 1'b1;
      @(negedge clk);
      bus.record_done = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      src_q.delete();
      exp_q.delete();
      bus.varint_fifo_full = 1'b0;
      bus.raw_fifo_full    = 1'b0;
      bus.record_done      = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   vec_t vecs [6];

   initial begin
      int snap;
      int stall_pops;
      int drop;
      int n;
      logic seen;
      logic [DATA_W-1:0] d;

      bus.varint_fifo_full = 1'b0;
      bus.raw_fifo_full    = 1'b0;
      bus.record_done      = 1'b0;

      vecs[0] = '{64'hA5A5_0000_0000_0001, 1'b1, 1'b0, 1'b1, 10'd0, 10'd0};
      vecs[1] = '{64'hA5A5_0000_0000_0002, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
      vecs[2] = '{64'hA5A5_0000_0000_0003, 1'b1, 1'b1, 1'b1, 10'd0, 10'd1};
      vecs[3] = '{64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0, 10'd1, 10'd1};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 10'd1, 10'd2};
      vecs[5] = '{64'h0000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 10'd2, 10'd3};

      // Reset values
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_clr",      32'(bus.dst_fifo_clr),     32'd1);
      check("rst_pop",      32'(bus.in_fifo_pop),      32'd0);
      check("rst_vpush",    32'(bus.varint_fifo_push), 32'd0);
      check("rst_rpush",    32'(bus.raw_fifo_push),    32'd0);
      check("rst_err",      32'(bus.dispatch_err),     32'd0);
      check("rst_index",    32'(dbg_in_index),         32'd0);
      check("rst_inflight", 32'(dbg_inflight),         32'd0);
      check("rst_state",    32'(dbg_state),            32'(ST_INIT));
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("clr_after_release", 32'(bus.dst_fifo_clr), 32'd1);
      @(negedge clk);
      check("clr_dropped", 32'(bus.dst_fifo_clr), 32'd0);
      check("idle_after_init", 32'(dbg_state), 32'(ST_IDLE));

      // Table-driven single words: routing, index, pop-to-push spacing
      for (int i = 0; i < 6; i++) begin
         enq(vecs[i].data, vecs[i].is_varint, vecs[i].last);
         expect_push(vecs[i].exp_dest, vecs[i].exp_index, vecs[i].data);
         wait_done(20, "vec");
         check("vec_pop_to_push", 32'(push_cyc - pop_cyc), 32'd2);
         @(negedge clk);
         check("vec_index_after", 32'(dbg_in_index), 32'(vecs[i].exp_idx_after));
      end

      // Throughput: one record of 3 words queued at once
      enq(64'hCAFE_0000_0000_0001, 1'b1, 1'b0);
      enq(64'hCAFE_0000_0000_0002, 1'b0, 1'b0);
      enq(64'hCAFE_0000_0000_0003, 1'b1, 1'b1);
      expect_push(1'b1, 10'd3, 64'hCAFE_0000_0000_0001);
      expect_push(1'b0, 10'd3, 64'hCAFE_0000_0000_0002);
      expect_push(1'b1, 10'd3, 64'hCAFE_0000_0000_0003);
      wait_done(40, "thru");
      check("thru_push_spacing", 32'(push_cyc - prev_push_cyc), 32'd4);
      @(negedge clk);
      check("thru_index_after", 32'(dbg_in_index), 32'd4);

      // Back-pressure on the raw FIFO for 10 cycles
      do_reset();
      bus.raw_fifo_full = 1'b1;
      enq(64'hBEEF_0000_0000_00AA, 1'b0, 1'b1);
      enq(64'hBEEF_0000_0000_00BB, 1'b1, 1'b1);
      expect_push(1'b0, 10'd0, 64'hBEEF_0000_0000_00AA);
      expect_push(1'b1, 10'd1, 64'hBEEF_0000_0000_00BB);
      wait_state(ST_DISPATCH, 20, "bp_reach_dispatch");
      snap = push_cnt;
      stall_pops = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.in_fifo_pop === 1'b1) stall_pops++;
      end
      check("bp_no_push",  32'(push_cnt - snap), 32'd0);
      check("bp_no_pop",   32'(stall_pops),      32'd0);
      check("bp_held",     32'(dbg_state),       32'(ST_DISPATCH));
      bus.raw_fifo_full = 1'b0;
      drop = cyc;
      wait_done(20, "bp");
      check("bp_push_cycle_after_drop", 32'(prev_push_cyc - drop), 32'd1);

      // Reset mid-operation with the destination full
      bus.varint_fifo_full = 1'b1;
      enq(64'hDEAD_0000_0000_0001, 1'b1, 1'b1);
      wait_state(ST_DISPATCH, 20, "mid_reach_dispatch");
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_vpush", 32'(bus.varint_fifo_push), 32'd0);
      check("mid_rpush", 32'(bus.raw_fifo_push),    32'd0);
      check("mid_clr",   32'(bus.dst_fifo_clr),     32'd1);
      check("mid_state", 32'(dbg_state),            32'(ST_INIT));
      src_q.delete();
      bus.varint_fifo_full = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_index_cleared", 32'(dbg_in_index), 32'd0);
      enq(64'h0BAD_F00D_0000_0001, 1'b0, 1'b1);
      expect_push(1'b0, 10'd0, 64'h0BAD_F00D_0000_0001);
      wait_done(20, "mid_first");
      @(negedge clk);
      check("mid_index_after", 32'(dbg_in_index), 32'd1);

      // Index wrap: 1025 single-word records, completion returned each time
      do_reset();
      for (int i = 0; i < 1025; i++) begin
         d = {32'hC0DE_0000, 32'(i)};
         enq(d, i[0], 1'b1);
         expect_push(i[0], 10'(i), d);
         wait_done(20, "wrap");
         pulse_done();
      end
      @(negedge clk);
      check("wrap_index_after", 32'(dbg_in_index),     32'd1);
      check("wrap_no_err",      32'(bus.dispatch_err), 32'd0);
      check("wrap_inflight",    32'(dbg_inflight),     32'd0);

      // In-flight window
      do_reset();
      snap = push_cnt;
`ifdef INFLIGHT_LIMIT_EN
      for (int i = 0; i < 6; i++) begin
         enq(64'h5000 + 64'(i), i[0], 1'b1);
         if (i < 4) expect_push(i[0], 10'(i), 64'h5000 + 64'(i));
      end
      repeat (40) @(negedge clk);
      check("win_pushes",   32'(push_cnt - snap), 32'd4);
      check("win_idle",     32'(dbg_state),       32'(ST_IDLE));
      check("win_inflight", 32'(dbg_inflight),    32'd4);
      check("win_src_left", 32'(src_q.size()),    32'd2);
      expect_push(1'b0, 10'd4, 64'h5004);
      pulse_done();
      wait_done(30, "win_fifth");
      repeat (4) @(negedge clk);
      check("win_one_more",       32'(push_cnt - snap), 32'd5);
      check("win_inflight_again", 32'(dbg_inflight),    32'd4);
      expect_push(1'b1, 10'd5, 64'h5005);
      pulse_done();
      seen = 1'b0;
      n = 0;
      while (!seen && n < 30) begin
         @(negedge clk);
         n++;
         if (bus.varint_fifo_push === 1'b1 || bus.raw_fifo_push === 1'b1) seen = 1'b1;
      end
      check("win_coincide_seen", 32'(seen), 32'd1);
      bus.record_done = 1'b1;
      @(negedge clk);
      bus.record_done = 1'b0;
      repeat (2) @(negedge clk);
      check("win_coincide_inflight", 32'(dbg_inflight),     32'd3);
      check("win_coincide_no_err",   32'(bus.dispatch_err), 32'd0);
`else
      for (int i = 0; i < 6; i++) begin
         enq(64'h5000 + 64'(i), i[0], 1'b1);
         expect_push(i[0], 10'(i), 64'h5000 + 64'(i));
      end
      wait_done(60, "win_open");
      check("win_open_pushes",   32'(push_cnt - snap), 32'd6);
      check("win_open_inflight", 32'(dbg_inflight),    32'd0);
`endif

      // Error: completion with nothing in flight
      do_reset();
      pulse_done();
      @(negedge clk);
`ifdef INFLIGHT_LIMIT_EN
      check("err_set", 32'(bus.dispatch_err), 32'd1);
      repeat (5) @(negedge clk);
      check("err_sticky", 32'(bus.dispatch_err), 32'd1);
      enq(64'h7777, 1'b1, 1'b1);
      expect_push(1'b1, 10'd0, 64'h7777);
      wait_done(20, "err_traffic");
      check("err_sticky_traffic", 32'(bus.dispatch_err), 32'd1);
      do_reset();
      check("err_cleared_by_reset", 32'(bus.dispatch_err), 32'd0);
`else
      check("err_ignored_done", 32'(bus.dispatch_err), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
